// File: rtl/an_encoder_seq_if.sv
// Handshake bundle for the AN encoder: input word side (with injection request) and codeword side.
// master = data source / consumer environment, slave = encoder.
interface an_encoder_seq_if #(
   parameter int DATA_W = 52,
   parameter int CW_W   = 60
);
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   in_data;
   logic                inj_en;
   logic signed [6:0]   inj_loc;
   logic                out_valid;
   logic                out_ready;
   logic [CW_W-1:0]     out_cw;
   logic                out_injected;

   modport master (
      output in_valid, in_data, inj_en, inj_loc, out_ready,
      input  in_ready, out_valid, out_cw, out_injected
   );

   modport slave (
      input  in_valid, in_data, inj_en, inj_loc, out_ready,
      output in_ready, out_valid, out_cw, out_injected
   );
endinterface

// File: rtl/an_encoder_seq.sv
// Sequential AN code encoder: codeword = A * data via shift-and-add, one bit of A per cycle (A_W cycles).
// Optional single-bit error injection on the codeword is built only when AN_ERR_INJECT_EN is defined.
module an_encoder_seq #(
   parameter int DATA_W = 52,
   parameter int A      = 131,
   parameter int A_W    = 8,
   parameter int CW_W   = 60
) (
   input logic             clk,
   input logic             rst,
   an_encoder_seq_if.slave bus
);
   localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;
   localparam logic [A_W-1:0] A_BITS = A_W'(A);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   data_q;
   logic [CW_W-1:0]     acc, acc_nxt, cw_fin, cw_q;
   logic [CNT_W-1:0]    cnt;
   logic                last, inj_fin, inj_q;

   assign last    = (cnt == CNT_W'(A_W - 1));
   assign acc_nxt = A_BITS[cnt] ? acc + (CW_W'(data_q) << cnt) : acc;

`ifdef AN_ERR_INJECT_EN
   logic              inj_en_q;
   logic signed [6:0] inj_loc_q;
   logic [6:0]        mag;
   logic              hit;
   logic [CW_W-1:0]   delta;

   // +k adds 2^(k-1), -k subtracts it; out-of-range locations mean no injection
   assign mag     = inj_loc_q[6] ? $unsigned(-inj_loc_q) : $unsigned(inj_loc_q);
   assign hit     = inj_en_q && (mag != 7'd0) && (mag <= 7'(CW_W));
   assign delta   = CW_W'(1) << (mag - 7'd1);
   assign cw_fin  = !hit ? acc_nxt : (inj_loc_q[6] ? acc_nxt - delta : acc_nxt + delta);
   assign inj_fin = hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_en_q  <= 1'b0;
         inj_loc_q <= '0;
      end else if (state == IDLE && bus.in_valid) begin
         inj_en_q  <= bus.inj_en;
         inj_loc_q <= bus.inj_loc;
      end
   end
`else
   logic unused_inj;
   assign unused_inj = ^{bus.inj_en, bus.inj_loc};
   assign cw_fin     = acc_nxt;
   assign inj_fin    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = CALC;
         CALC:    if (last)          state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         acc    <= '0;
         cnt    <= '0;
         cw_q   <= '0;
         inj_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               data_q <= bus.in_data;
               acc    <= '0;
               cnt    <= '0;
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + CNT_W'(1);
               // the last add lands directly in the output register
               if (last) begin
                  cw_q  <= cw_fin;
                  inj_q <= inj_fin;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_cw       = cw_q;
   assign bus.out_injected = inj_q;
endmodule

// File: doc/an_encoder_seq.md
Name: an_encoder_seq

Overview:
- Sequential AN (product) code encoder; the transmit-side counterpart of the SEC location decoder.
- Computes codeword = A × data with a shift-and-add over the bits of A, one bit per cycle.
- Default A = 131; 2 has order 130 mod 131, so every single-bit ±2^k error leaves a distinct nonzero remainder.
- Sits between the data source and the storage/channel, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 52, data word width.
- A, 131, AN code multiplier (odd, < 2^A_W).
- A_W, 8, width of A; also the number of CALC iterations.
- CW_W, 60, codeword width; equals DATA_W + A_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  data offered.
- in_ready  output  1  encoder can accept data.
- in_data  input  DATA_W  unsigned data word.
- inj_en  input  1  request error injection on this word. Sampled with in_data.
- inj_loc  input  7 (signed)  injection location ±1..±CW_W. Same convention as decoder output: +k adds 2^(k-1), -k subtracts 2^(k-1).
- out_valid  output  1  codeword available.
- out_ready  input  1  consumer accepts codeword.
- out_cw  output  CW_W  encoded word.
- out_injected  output  1  an error was injected into out_cw.

Behaviour:
- Reset values (async, immediate on rst=1): state=IDLE, in_ready=1, out_valid=0, out_cw=0, out_injected=0, acc=0, cnt=0, captured data/inj regs=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data, inj_en, inj_loc; acc<=0; cnt<=0; go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: if A[cnt]=1, acc <= acc + (data << cnt), computed at CW_W bits; cnt++.
  - When cnt==A_W-1, the final add is performed and the state goes to DONE.
  - Exactly A_W CALC cycles. out_valid rises A_W cycles after the acceptance edge (8 by default).
- DONE entry edge:
  - out_cw <= acc, plus injection if enabled (see Optional Feature).
  - out_valid=1; out_cw and out_injected held stable until handshake.
- DONE:
  - On out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE, so there is no overlap. Throughput is one word per A_W+2 cycles when out_ready=1.
- Arithmetic: the product never overflows CW_W, since A < 2^A_W. Max (2^52-1)×131 = 0x82FFFFFFFFFFF7D.
- Injection wraps modulo 2^CW_W.
- out_ready asserted while not in DONE: ignored.
- in_valid dropped mid-CALC: ignored; the data is already captured.
- rst asserted mid-CALC or mid-DONE: aborts immediately to reset values. The pending word is lost.
- The in_valid source must hold in_data stable until in_ready handshake (standard valid/ready).

Optional Feature:
- Macro: AN_ERR_INJECT_EN.
- Defined:
  - At the DONE entry edge, if captured inj_en=1 and 1≤|inj_loc|≤CW_W: out_cw <= acc ± 2^(|inj_loc|-1) (sign of inj_loc), and out_injected<=1.
  - Otherwise out_cw<=acc and out_injected<=0. inj_loc=0 or |inj_loc|>CW_W means no injection.
- Undefined:
  - inj_en and inj_loc are present but ignored; no injection logic is synthesised.
  - out_injected is tied 0; out_cw=acc always.

Test Plan:
- Reset then in_data=1, out_ready=1 -> out_valid high exactly 8 cycles after acceptance, out_cw=131, out_injected=0, in_ready low throughout CALC/DONE.
- in_data=2^52-1 -> out_cw=0x82FFFFFFFFFFF7D. in_data=0 -> out_cw=0. in_data=1000 -> out_cw=131000.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_cw stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> IDLE next cycle, in_ready=1.
- With AN_ERR_INJECT_EN: in_data=1, inj_en=1, inj_loc=+3 -> out_cw=135 (135 mod 131=4, decoder returns +3). inj_loc=-1 -> out_cw=130 (decoder returns -1). inj_loc=61 -> out_cw=131, out_injected=0.
- Without AN_ERR_INJECT_EN: same stimulus inj_en=1, inj_loc=+3 -> out_cw=131, out_injected=0.
- Assert rst for 1 cycle at CALC cycle 4 -> outputs return to reset values asynchronously, no out_valid. A subsequent in_data=5 -> out_cw=655.
